// File: rtl/pipe_stage_pkg.sv
// Shared pipeline definitions: inter-stage bundle layouts and counter defaults.
// Every stage packs and unpacks its bundle through these offsets so the
// producer and consumer of a pipe_stage always agree on the field layout.
package pipe_stage_pkg;

    // Default width of the performance/backpressure counters.
    localparam int DEFAULT_CNT_W = 16;

    // ID/EX bundle: operands, immediate, destination and ALU control.
    localparam int IDEX_PC_LSB     = 0;
    localparam int IDEX_PC_W       = 32;
    localparam int IDEX_RS1_LSB    = IDEX_PC_LSB + IDEX_PC_W;
    localparam int IDEX_RS1_W      = 32;
    localparam int IDEX_RS2_LSB    = IDEX_RS1_LSB + IDEX_RS1_W;
    localparam int IDEX_RS2_W      = 32;
    localparam int IDEX_IMM_LSB    = IDEX_RS2_LSB + IDEX_RS2_W;
    localparam int IDEX_IMM_W      = 32;
    localparam int IDEX_RD_LSB     = IDEX_IMM_LSB + IDEX_IMM_W;
    localparam int IDEX_RD_W       = 5;
    localparam int IDEX_ALUOP_LSB  = IDEX_RD_LSB + IDEX_RD_W;
    localparam int IDEX_ALUOP_W    = 4;
    localparam int IDEX_W          = IDEX_ALUOP_LSB + IDEX_ALUOP_W;

    // EX/MEM bundle: ALU result, store data, destination and memory control.
    localparam int EXMEM_RES_LSB   = 0;
    localparam int EXMEM_RES_W     = 32;
    localparam int EXMEM_STD_LSB   = EXMEM_RES_LSB + EXMEM_RES_W;
    localparam int EXMEM_STD_W     = 32;
    localparam int EXMEM_RD_LSB    = EXMEM_STD_LSB + EXMEM_STD_W;
    localparam int EXMEM_RD_W      = 5;
    localparam int EXMEM_MEMOP_LSB = EXMEM_RD_LSB + EXMEM_RD_W;
    localparam int EXMEM_MEMOP_W   = 3;
    localparam int EXMEM_W         = EXMEM_MEMOP_LSB + EXMEM_MEMOP_W;

    // MEM/WB bundle: write-back value, destination and write enable.
    localparam int MEMWB_VAL_LSB   = 0;
    localparam int MEMWB_VAL_W     = 32;
    localparam int MEMWB_RD_LSB    = MEMWB_VAL_LSB + MEMWB_VAL_W;
    localparam int MEMWB_RD_W      = 5;
    localparam int MEMWB_WE_LSB    = MEMWB_RD_LSB + MEMWB_RD_W;
    localparam int MEMWB_WE_W      = 1;
    localparam int MEMWB_W         = MEMWB_WE_LSB + MEMWB_WE_W;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous active-low clear. Used for bp_cnt
// and intended for reuse by the other performance counters.
module sat_counter
    import pipe_stage_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline-stage register with valid/ready handshake, stall, flush
// and an optional skid entry that cuts the out_ready -> in_ready path.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] bp_cnt
);

    logic             m_valid_reg;
    logic [WIDTH-1:0] m_data_reg;
    logic             accept_ok;
    logic             in_fire;
    logic             out_fire;
    logic             bp_inc;

    // Stall and flush block both sides of the handshake; out_data stays
    // register-driven so downstream sees the held payload during a stall.
    assign accept_ok = clr_n & ~stall & ~flush;
    assign out_valid = m_valid_reg & ~stall & ~flush;
    assign out_data  = m_data_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign bp_inc    = out_valid & ~out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             s_valid_reg;
            logic [WIDTH-1:0] s_data_reg;

            // Ready depends only on the skid register, never on out_ready.
            assign in_ready = accept_ok & ~s_valid_reg;

            // Two-entry FIFO: M feeds the output, S catches the entry
            // accepted while M was blocked.
            always_ff @(posedge clk) begin
                if (!clr_n || flush) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                    s_valid_reg <= 1'b0;
                    s_data_reg  <= '0;
                end else if (out_fire) begin
                    if (s_valid_reg) begin
                        m_data_reg  <= s_data_reg;
                        s_valid_reg <= 1'b0;
                    end else if (in_fire) begin
                        m_data_reg <= in_data;
                    end else begin
                        m_valid_reg <= 1'b0;
                    end
                end else if (in_fire) begin
                    if (!m_valid_reg) begin
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= in_data;
                    end else begin
                        s_valid_reg <= 1'b1;
                        s_data_reg  <= in_data;
                    end
                end
            end
        end else begin : g_single
            // Single entry: a full stage can refill in the cycle it drains.
            assign in_ready = accept_ok & (~m_valid_reg | out_ready);

            // Load on accept, empty on an emit that is not refilled.
            always_ff @(posedge clk) begin
                if (!clr_n || flush) begin
                    m_valid_reg <= 1'b0;
                    m_data_reg  <= '0;
                end else if (in_fire) begin
                    m_valid_reg <= 1'b1;
                    m_data_reg  <= in_data;
                end else if (out_fire) begin
                    m_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (bp_inc),
        .count (bp_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: skid variant, single-entry variant and
// a narrow-counter instance, with a data scoreboard on each streaming DUT.
module tb_pipe_stage;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DUT A: SKID=1, 16-bit counter
    logic        a_flush, a_stall, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_bp_cnt;
    // DUT B: SKID=0
    logic        b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [15:0] b_bp_cnt;
    // DUT C: SKID=1, 3-bit counter
    logic        c_flush, c_stall, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [2:0]  c_bp_cnt;

    pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .clr_n(clr_n), .flush(a_flush), .stall(a_stall),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .bp_cnt(a_bp_cnt));

    pipe_stage #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .clr_n(clr_n), .flush(b_flush), .stall(b_stall),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .bp_cnt(b_bp_cnt));

    pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(3)) u_c (
        .clk(clk), .clr_n(clr_n), .flush(c_flush), .stall(c_stall),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .bp_cnt(c_bp_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic r,
                           input logic st, input logic fl);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = r;
        a_stall     = st;
        a_flush     = fl;
    endtask

    // Scoreboards: push on accept, pop and compare on emit.
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_sb_spurious", 32'd1, 32'd0);
            else chk("a_sb_data", a_out_data, qa.pop_front());
        end
        if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        if (a_flush || !clr_n) qa.delete();
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_sb_spurious", 32'd1, 32'd0);
            else chk("b_sb_data", b_out_data, qb.pop_front());
        end
        if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        if (b_flush || !clr_n) qb.delete();
    end

    // Bench-side occupancy model for the single-entry DUT.
    logic mv;
    logic inf, outf;

    initial begin
        clr_n = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        b_flush = 0; b_stall = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        c_flush = 0; c_stall = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;

        // Reset for two cycles
        repeat (2) begin
            settle();
            chk("rst_a_in_ready", 32'(a_in_ready), 32'd0);
            chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
            chk("rst_a_out_data", a_out_data, 32'd0);
            chk("rst_a_bp_cnt", 32'(a_bp_cnt), 32'd0);
            chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
            chk("rst_c_bp_cnt", 32'(c_bp_cnt), 32'd0);
            tick();
        end
        clr_n = 1'b1;
        settle();
        chk("rel_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rel_b_in_ready", 32'(b_in_ready), 32'd1);
        chk("rel_a_out_valid", 32'(a_out_valid), 32'd0);
        tick();

        // Stream 1..4 with out_ready high: one per cycle, one cycle latency
        for (int i = 0; i < 6; i++) begin
            drive_a(i < 4, 32'(i + 1), 1, 0, 0);
            settle();
            if (i == 0) begin
                chk("stream_empty", 32'(a_out_valid), 32'd0);
            end else if (i <= 4) begin
                chk("stream_valid", 32'(a_out_valid), 32'd1);
                chk("stream_data", a_out_data, 32'(i));
            end else begin
                chk("stream_drained", 32'(a_out_valid), 32'd0);
            end
            tick();
        end

        // Backpressure: A in M, B in S, C refused until S drains
        drive_a(1, 32'hA0A0, 0, 0, 0); settle();
        chk("bp_acc_a", 32'(a_in_ready), 32'd1);
        tick();
        drive_a(1, 32'hB0B0, 0, 0, 0); settle();
        chk("bp_acc_b", 32'(a_in_ready), 32'd1);
        chk("bp_hold_a", a_out_data, 32'hA0A0);
        tick();
        drive_a(1, 32'hC0C0, 0, 0, 0); settle();
        chk("bp_full_1", 32'(a_in_ready), 32'd0);
        chk("bp_hold_a2", a_out_data, 32'hA0A0);
        tick();
        drive_a(1, 32'hC0C0, 0, 0, 0); settle();
        chk("bp_full_2", 32'(a_in_ready), 32'd0);
        tick();
        drive_a(1, 32'hC0C0, 1, 0, 0); settle();
        chk("bp_cnt_3", 32'(a_bp_cnt), 32'd3);
        chk("bp_rel_a", a_out_data, 32'hA0A0);
        chk("bp_rel_full", 32'(a_in_ready), 32'd0);
        tick();
        drive_a(1, 32'hC0C0, 1, 0, 0); settle();
        chk("bp_rel_b", a_out_data, 32'hB0B0);
        chk("bp_rel_ready", 32'(a_in_ready), 32'd1);
        tick();
        drive_a(0, 0, 1, 0, 0); settle();
        chk("bp_rel_c_valid", 32'(a_out_valid), 32'd1);
        chk("bp_rel_c", a_out_data, 32'hC0C0);
        tick();
        settle();
        chk("bp_empty", 32'(a_out_valid), 32'd0);
        tick();

        // Flush with M and S full and C offered
        drive_a(1, 32'h11, 0, 0, 0); settle(); tick();
        drive_a(1, 32'h22, 0, 0, 0); settle(); tick();
        drive_a(1, 32'h33, 0, 0, 1); settle();
        chk("fl_out_valid_t", 32'(a_out_valid), 32'd0);
        chk("fl_in_ready_t", 32'(a_in_ready), 32'd0);
        tick();
        drive_a(0, 0, 0, 0, 0); settle();
        chk("fl_out_valid_t1", 32'(a_out_valid), 32'd0);
        chk("fl_out_data", a_out_data, 32'd0);
        chk("fl_in_ready", 32'(a_in_ready), 32'd1);
        chk("fl_bp_cnt", 32'(a_bp_cnt), 32'd4);
        tick();
        drive_a(0, 0, 1, 0, 0); settle();
        chk("fl_c_dropped", 32'(a_out_valid), 32'd0);
        tick();

        // Stall for two cycles with A held in M
        drive_a(1, 32'h55, 1, 0, 0); settle(); tick();
        repeat (2) begin
            drive_a(1, 32'h66, 1, 1, 0); settle();
            chk("st_out_valid", 32'(a_out_valid), 32'd0);
            chk("st_in_ready", 32'(a_in_ready), 32'd0);
            chk("st_data", a_out_data, 32'h55);
            chk("st_bp_cnt", 32'(a_bp_cnt), 32'd4);
            tick();
        end
        drive_a(0, 0, 1, 0, 0); settle();
        chk("st_resume_valid", 32'(a_out_valid), 32'd1);
        chk("st_resume_data", a_out_data, 32'h55);
        tick();
        settle();
        chk("st_done", 32'(a_out_valid), 32'd0);
        chk("a_sb_left", 32'(qa.size()), 32'd0);
        tick();

        // Counter saturation on the 3-bit instance
        c_in_valid = 1; c_in_data = 32'h7; c_out_ready = 0;
        settle(); tick();
        c_in_valid = 0;
        for (int j = 1; j <= 11; j++) begin
            settle();
            chk("sat_valid", 32'(c_out_valid), 32'd1);
            chk("sat_bp_cnt", 32'(c_bp_cnt), (j - 1 > 7) ? 32'd7 : 32'(j - 1));
            tick();
        end

        // SKID=0: out_ready toggles, ready follows it combinationally
        mv = 1'b0;
        for (int i = 0; i < 100; i++) begin
            b_in_valid  = (i < 50) ? 1'b1 : 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            b_out_ready = 1'(i % 2);
            settle();
            chk("b_out_valid", 32'(b_out_valid), 32'(mv));
            chk("b_in_ready", 32'(b_in_ready), 32'(!mv || b_out_ready));
            inf  = b_in_valid && (!mv || b_out_ready);
            outf = mv && b_out_ready;
            mv   = inf ? 1'b1 : (outf ? 1'b0 : mv);
            tick();
        end
        b_in_valid  = 0;
        b_out_ready = 1;
        repeat (2) begin settle(); tick(); end
        settle();
        chk("b_drained", 32'(b_out_valid), 32'd0);
        chk("b_sb_left", 32'(qb.size()), 32'd0);
        chk("b_bp_nonzero", 32'(b_bp_cnt != 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
